ternary_seq_adder: RTL

Parametrised, sequential unbalanced-ternary arithmetic unit. Processes TRITS-wide operands, 2 bits per trit, at TRITS_PER_CYCLE trits per clock, least-significant group first. Supports add, subtract, accumulator load and accumulate, with start/busy/done handshake and invalid-code detection. It is the multi-cycle, multi-mode successor to the combinational 8-trit ripple adder, sized for wide ternary datapaths where a full ripple chain is too slow.

---
 rtl/ternary_seq_adder.sv | 96 +++++++++
 1 files changed

// File: rtl/ternary_seq_adder.sv
// ternary_seq_adder: multi-cycle unbalanced-ternary add/sub/accumulate/load unit.
module ternary_seq_adder #(
  parameter int TRITS = 8,
  parameter int TRITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [2*TRITS-1:0] sum,
  output logic [1:0]         overflow,
  output logic               invalid,
  output logic [2*TRITS-1:0] acc
);
  localparam int N = 2*TRITS;
  localparam int GW = 2*TRITS_PER_CYCLE;
  localparam int K = TRITS/TRITS_PER_CYCLE;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] x_r, y_r, s_r, gd, s_n, y_in;
  logic [1:0] op_r;
  logic c_r, c_n, inv_r, inv_in, last;
  logic [CW-1:0] cnt;
  logic [2:0] t;
  assign last = cnt == CW'(K-1);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_comb busy = state == RUN;
  // second operand per mode: b, its trit complement (2-b), the accumulator, or zero for load
  always_comb begin
    y_in = '0;
    inv_in = 1'b0;
    for (int i = 0; i < TRITS; i++) begin
      y_in[2*i+:2] = mode == 2'b01 ? 2'(2'd2 - b[2*i+:2]) : mode == 2'b00 ? b[2*i+:2] : mode == 2'b10 ? acc[2*i+:2] : 2'b00;
      inv_in = inv_in | (&a[2*i+:2]) | (~mode[1] & (&b[2*i+:2]));
    end
  end
  always_comb begin
    gd = '0;
    c_n = c_r;
    t = '0;
    for (int i = 0; i < TRITS_PER_CYCLE; i++) begin
      t = {1'b0, x_r[2*i+:2]} + {1'b0, y_r[2*i+:2]} + {2'b00, c_n};
      c_n = t >= 3'd3;
      gd[2*i+:2] = c_n ? 2'(t - 3'd3) : t[1:0];
    end
    s_n = (s_r >> GW) | (gd << (N - GW));
  end
  // operands shift right one group per cycle; result groups enter from the top
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      c_r <= 1'b0;
      x_r <= '0;
      y_r <= '0;
      s_r <= '0;
      op_r <= 2'b00;
      inv_r <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      overflow <= 2'b00;
      invalid <= 1'b0;
      acc <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x_r <= a;
          y_r <= y_in;
          op_r <= mode;
          inv_r <= inv_in;
          c_r <= mode == 2'b01;
          cnt <= '0;
          s_r <= '0;
        end
      end else begin
        x_r <= x_r >> GW;
        y_r <= y_r >> GW;
        s_r <= s_n;
        c_r <= c_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          invalid <= inv_r;
          sum <= inv_r ? '0 : s_n;
          overflow <= {1'b0, ~inv_r & (op_r == 2'b01 ? ~c_n : (op_r != 2'b11) & c_n)};
          if (op_r[1] && !inv_r) acc <= s_n;
        end
      end
    end
endmodule
